neuron_event_scheduler: RTL and testbench



---
 rtl/neuron_event_scheduler_pkg.sv | 16 +
 rtl/neuron_event_scheduler_if.sv | 21 ++
 rtl/neuron_event_scheduler_syn_event_decode.sv | 55 +++++
 rtl/neuron_event_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_neuron_event_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_event_scheduler_pkg.sv
// Shared types and defaults for the neuron event scheduler.
// No ports: state enum, sign-bit position and default leak pacing.
package nhap_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SYN,
      LEAK,
      DRAIN
   } sched_state_e;

   localparam int DEF_SYN_WEIGHT_WIDTH = 4;
   localparam int SYN_SIGN_BIT = DEF_SYN_WEIGHT_WIDTH - 1;
   localparam int DEF_LEAK_GAP = 4;

endpackage

// File: rtl/neuron_event_scheduler_if.sv
// AER pre-synaptic spike handshake bundle.
// master drives valid/addr, slave returns ready.
interface neuron_event_scheduler_if #(
   parameter int PRE_AW = 8
);
   logic              aer_in_valid;
   logic [PRE_AW-1:0] aer_in_addr;
   logic              aer_in_ready;

   modport master (
      output aer_in_valid,
      output aer_in_addr,
      input  aer_in_ready
   );

   modport slave (
      input  aer_in_valid,
      input  aer_in_addr,
      output aer_in_ready
   );
endinterface

// File: rtl/neuron_event_scheduler_syn_event_decode.sv
// Registered synapse-word decode: turns one SRAM read into exc/inh strobe.
// Ports: CLK/RST, rd_data/rd_post/rd_vld in; event_exc/inh, weight, addr out.
module syn_event_decode
   import nhap_sched_pkg::*;
#(
   parameter int NEUR_AW          = 8,
   parameter int SYN_WEIGHT_WIDTH = DEF_SYN_WEIGHT_WIDTH
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [SYN_WEIGHT_WIDTH-1:0] rd_data,
   input  logic [NEUR_AW-1:0]          rd_post,
   input  logic                        rd_vld,
   output logic                        event_exc,
   output logic                        event_inh,
   output logic [SYN_WEIGHT_WIDTH-1:0] syn_weight,
   output logic [NEUR_AW-1:0]          neur_addr
);
   localparam int SB = SYN_WEIGHT_WIDTH - 1;

   logic                        exc_d, exc_q;
   logic                        inh_d, inh_q;
   logic [SYN_WEIGHT_WIDTH-1:0] wgt_d, wgt_q;
   logic [NEUR_AW-1:0]          addr_d, addr_q;
   logic                        mag_nz;

   // zero magnitude means no synapse, whatever the sign bit says
   always_comb begin
      mag_nz = |rd_data[SB-1:0];
      exc_d  = rd_vld & mag_nz & ~rd_data[SB];
      inh_d  = rd_vld & mag_nz & rd_data[SB];
      wgt_d  = rd_vld ? rd_data : '0;
      addr_d = rd_vld ? rd_post : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         exc_q  <= 1'b0;
         inh_q  <= 1'b0;
         wgt_q  <= '0;
         addr_q <= '0;
      end else begin
         exc_q  <= exc_d;
         inh_q  <= inh_d;
         wgt_q  <= wgt_d;
         addr_q <= addr_d;
      end
   end

   assign event_exc  = exc_q;
   assign event_inh  = inh_q;
   assign syn_weight = wgt_q;
   assign neur_addr  = addr_q;

endmodule

// File: rtl/neuron_event_scheduler.sv
// Spike/leak event scheduler feeding the neuron state-update datapath.
// Ports: CLK/RST, aer (slave), tick/clear_req, synapse SRAM read, event outputs.
module neuron_event_scheduler
   import nhap_sched_pkg::*;
#(
   parameter int N_NEUR           = 256,
   parameter int NEUR_AW          = 8,
   parameter int PRE_AW           = 8,
   parameter int SYN_WEIGHT_WIDTH = DEF_SYN_WEIGHT_WIDTH,
   parameter int LEAK_GAP         = DEF_LEAK_GAP
) (
   input  logic                        CLK,
   input  logic                        RST,
   neuron_event_scheduler_if.slave     aer,
   input  logic                        tick,
   input  logic                        clear_req,
   output logic                        syn_rd_en,
   output logic [PRE_AW+NEUR_AW-1:0]   syn_rd_addr,
   input  logic [SYN_WEIGHT_WIDTH-1:0] syn_rd_data,
   output logic [NEUR_AW-1:0]          neur_addr,
   output logic                        event_exc,
   output logic                        event_inh,
   output logic                        event_leak,
   output logic [SYN_WEIGHT_WIDTH-1:0] syn_weight,
   output logic                        global_leak_time,
   output logic                        busy,
   output logic                        sweep_done,
   output logic                        tick_overrun
);
   localparam int GW = (LEAK_GAP > 2) ? $clog2(LEAK_GAP) : 1;
   localparam logic [NEUR_AW-1:0] LAST = NEUR_AW'(N_NEUR - 1);
   localparam logic [GW-1:0] RELOAD = GW'(LEAK_GAP - 1);

   sched_state_e       state_q, state_d;
   logic [PRE_AW-1:0]  pre_q, pre_d;
   logic [NEUR_AW-1:0] cnt_q, cnt_d;
   logic [GW-1:0]      gap_q, gap_d;
   logic               drn_q, drn_d;
   logic               lend_q, lend_d;
   logic               tick_pend_q, tick_pend_d;
   logic               clr_pend_q, clr_pend_d;
   logic               clr_act_q, clr_act_d;
   logic               ovr_q, ovr_d;
   logic               rd_vld_q, rd_vld_d;
   logic [NEUR_AW-1:0] rd_post_q, rd_post_d;
   logic               leak_q, leak_d;
   logic               glt_q, glt_d;
   logic [NEUR_AW-1:0] lk_addr_q, lk_addr_d;
   logic               done_q, done_d;
   logic               rdy;
   logic               enter_leak;
   logic [NEUR_AW-1:0] dec_addr;

   // a tick in the same cycle beats a waiting spike
   assign rdy = (state_q == IDLE) & ~tick_pend_q & ~tick & ~RST;
   assign aer.aer_in_ready = rdy;

   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      cnt_d      = cnt_q;
      gap_d      = gap_q;
      drn_d      = drn_q;
      lend_d     = lend_q;
      clr_act_d  = clr_act_q;
      leak_d     = 1'b0;
      glt_d      = 1'b0;
      lk_addr_d  = '0;
      done_d     = 1'b0;
      enter_leak = 1'b0;
      syn_rd_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick_pend_q) begin
               state_d    = LEAK;
               enter_leak = 1'b1;
               cnt_d      = '0;
               gap_d      = '0;
               lend_d     = 1'b0;
               clr_act_d  = clr_pend_q;
            end else if (aer.aer_in_valid && rdy) begin
               state_d = SYN;
               pre_d   = aer.aer_in_addr;
               cnt_d   = '0;
            end
         end
         SYN: begin
            syn_rd_en = 1'b1;
            cnt_d     = cnt_q + NEUR_AW'(1);
            if (cnt_q == LAST) begin
               state_d = DRAIN;
               drn_d   = 1'b0;
            end
         end
         DRAIN: begin
            // two cycles: last read data, then last strobe
            drn_d = 1'b1;
            if (drn_q) begin
               state_d = IDLE;
               drn_d   = 1'b0;
               done_d  = 1'b1;
            end
         end
         LEAK: begin
            // lend_q holds one extra cycle so done trails the last strobe
            if (lend_q) begin
               state_d   = IDLE;
               lend_d    = 1'b0;
               clr_act_d = 1'b0;
               done_d    = 1'b1;
            end else if (gap_q == '0) begin
               leak_d    = 1'b1;
               glt_d     = clr_act_q;
               lk_addr_d = cnt_q;
               gap_d     = RELOAD;
               cnt_d     = cnt_q + NEUR_AW'(1);
               lend_d    = (cnt_q == LAST);
            end else begin
               gap_d = gap_q - GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      tick_pend_d = tick | (tick_pend_q & ~enter_leak);
      clr_pend_d  = clear_req | (clr_pend_q & ~enter_leak);
      ovr_d       = ovr_q | (tick & tick_pend_q);
      rd_vld_d    = syn_rd_en;
      rd_post_d   = syn_rd_en ? cnt_q : '0;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         pre_q       <= '0;
         cnt_q       <= '0;
         gap_q       <= '0;
         drn_q       <= 1'b0;
         lend_q      <= 1'b0;
         tick_pend_q <= 1'b0;
         clr_pend_q  <= 1'b0;
         clr_act_q   <= 1'b0;
         ovr_q       <= 1'b0;
         rd_vld_q    <= 1'b0;
         rd_post_q   <= '0;
         leak_q      <= 1'b0;
         glt_q       <= 1'b0;
         lk_addr_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         gap_q       <= gap_d;
         drn_q       <= drn_d;
         lend_q      <= lend_d;
         tick_pend_q <= tick_pend_d;
         clr_pend_q  <= clr_pend_d;
         clr_act_q   <= clr_act_d;
         ovr_q       <= ovr_d;
         rd_vld_q    <= rd_vld_d;
         rd_post_q   <= rd_post_d;
         leak_q      <= leak_d;
         glt_q       <= glt_d;
         lk_addr_q   <= lk_addr_d;
         done_q      <= done_d;
      end
   end

   syn_event_decode #(
      .NEUR_AW          (NEUR_AW),
      .SYN_WEIGHT_WIDTH (SYN_WEIGHT_WIDTH)
   ) u_dec (
      .CLK        (CLK),
      .RST        (RST),
      .rd_data    (syn_rd_data),
      .rd_post    (rd_post_q),
      .rd_vld     (rd_vld_q),
      .event_exc  (event_exc),
      .event_inh  (event_inh),
      .syn_weight (syn_weight),
      .neur_addr  (dec_addr)
   );

   assign syn_rd_addr      = {pre_q, cnt_q};
   assign event_leak       = leak_q;
   assign global_leak_time = glt_q;
   assign neur_addr        = leak_q ? lk_addr_q : dec_addr;
   assign sweep_done       = done_q;
   assign tick_overrun     = ovr_q;
   assign busy             = (state_q != IDLE) | rd_vld_q;

endmodule

// File: tb/tb_neuron_event_scheduler.sv
// Directed bench for neuron_event_scheduler with N_NEUR=4, LEAK_GAP=3.
// Synapse SRAM is modelled with a one-cycle registered read.
`timescale 1ns/1ps
module tb_neuron_event_scheduler;
   localparam int N_NEUR   = 4;
   localparam int NEUR_AW  = 2;
   localparam int PRE_AW   = 8;
   localparam int WW       = 4;
   localparam int LEAK_GAP = 3;
   localparam int AW       = PRE_AW + NEUR_AW;
   localparam int EXC = 1;
   localparam int INH = 2;
   localparam int LK  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic clear_req = 1'b0;
   logic syn_rd_en;
   logic [AW-1:0] syn_rd_addr;
   logic [WW-1:0] syn_rd_data = '0;
   logic [NEUR_AW-1:0] neur_addr;
   logic event_exc, event_inh, event_leak;
   logic [WW-1:0] syn_weight;
   logic global_leak_time, busy, sweep_done, tick_overrun;
   logic [WW-1:0] mem [1<<AW];

   typedef struct {
      int t;
      int kind;
      int n;
      int w;
      int g;
   } ev_t;

   ev_t evq[$];
   int  doneq[$];
   int  n_chk = 0;
   int  n_pass = 0;
   int  rdy_cnt, rd_cnt, k;

   neuron_event_scheduler_if #(.PRE_AW(PRE_AW)) aer();

   neuron_event_scheduler #(
      .N_NEUR           (N_NEUR),
      .NEUR_AW          (NEUR_AW),
      .PRE_AW           (PRE_AW),
      .SYN_WEIGHT_WIDTH (WW),
      .LEAK_GAP         (LEAK_GAP)
   ) dut (
      .CLK              (clk),
      .RST              (rst),
      .aer              (aer),
      .tick             (tick),
      .clear_req        (clear_req),
      .syn_rd_en        (syn_rd_en),
      .syn_rd_addr      (syn_rd_addr),
      .syn_rd_data      (syn_rd_data),
      .neur_addr        (neur_addr),
      .event_exc        (event_exc),
      .event_inh        (event_inh),
      .event_leak       (event_leak),
      .syn_weight       (syn_weight),
      .global_leak_time (global_leak_time),
      .busy             (busy),
      .sweep_done       (sweep_done),
      .tick_overrun     (tick_overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (syn_rd_en) syn_rd_data <= mem[syn_rd_addr];
   end

   function automatic int now();
      return int'($time / 10);
   endfunction

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   // strobe logger samples 1 ns after the edge; stimulus runs at 2 ns
   always @(posedge clk) begin
      #1;
      if (event_exc | event_inh | event_leak) begin
         chk("mutex", int'(event_exc) + int'(event_inh)
             + int'(event_leak), 1);
         evq.push_back('{now(),
            event_exc ? EXC : (event_inh ? INH : LK),
            int'(neur_addr), int'(syn_weight),
            int'(global_leak_time)});
      end
      if (sweep_done) doneq.push_back(now());
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      rdy_cnt = 0;
      rd_cnt  = 0;
      repeat (n) begin
         step();
         rdy_cnt += int'(aer.aer_in_ready);
         rd_cnt  += int'(syn_rd_en);
      end
   endtask

   function automatic int dn(input int i);
      return (i < doneq.size()) ? doneq[i] : -1;
   endfunction

   task automatic chk_ev(input string tag, input int i, input int t,
                         input int kind, input int n, input int w,
                         input int g);
      if (i >= evq.size()) begin
         chk({tag, " missing"}, evq.size(), i + 1);
      end else begin
         chk({tag, " t"}, evq[i].t, t);
         chk({tag, " kind"}, evq[i].kind, kind);
         chk({tag, " n"}, evq[i].n, n);
         chk({tag, " g"}, evq[i].g, g);
         if (w >= 0) chk({tag, " w"}, evq[i].w, w);
      end
   endtask

   task automatic chk_leak(input string tag, input int i0,
                           input int t0, input int g);
      for (int i = 0; i < N_NEUR; i++)
         chk_ev($sformatf("%s l%0d", tag, i), i0 + i,
                t0 + LEAK_GAP * i, LK, i, -1, g);
   endtask

   task automatic clr_log();
      evq.delete();
      doneq.delete();
   endtask

   function automatic int outs();
      return int'({event_exc, event_inh, event_leak, global_leak_time,
                   busy, sweep_done, tick_overrun, syn_rd_en});
   endfunction

   initial begin
      for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
      mem[20] = 4'h3;
      mem[21] = 4'hA;
      mem[22] = 4'h0;
      mem[23] = 4'h8;
      aer.aer_in_valid = 1'b0;
      aer.aer_in_addr  = '0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst ready", int'(aer.aer_in_ready), 1);
      chk("rst outs", outs(), 0);
      chk("rst naddr", int'(neur_addr), 0);
      chk("rst wgt", int'(syn_weight), 0);

      // 1: spike on pre=5
      clr_log();
      k = now();
      aer.aer_in_valid = 1'b1;
      aer.aer_in_addr  = 8'd5;
      #1 chk("t1 ready", int'(aer.aer_in_ready), 1);
      step();
      aer.aer_in_valid = 1'b0;
      chk("t1 rd_en", int'(syn_rd_en), 1);
      chk("t1 rd_addr", int'(syn_rd_addr), 20);
      run(9);
      chk("t1 reads", rd_cnt, 3);
      chk("t1 nev", evq.size(), 2);
      chk_ev("t1 e0", 0, k + 3, EXC, 0, 3, 0);
      chk_ev("t1 e1", 1, k + 4, INH, 1, 10, 0);
      chk("t1 ndone", doneq.size(), 1);
      chk("t1 done", dn(0), k + 7);

      // 2: plain leak sweep
      clr_log();
      k = now();
      tick = 1'b1;
      #1 chk("t2 ready0", int'(aer.aer_in_ready), 0);
      step();
      tick = 1'b0;
      chk("t2 ready1", int'(aer.aer_in_ready), 0);
      run(11);
      chk("t2 ready run", rdy_cnt, 0);
      chk("t2 no reads", rd_cnt, 0);
      step();
      chk("t2 ready end", int'(aer.aer_in_ready), 1);
      chk("t2 done now", int'(sweep_done), 1);
      run(3);
      chk("t2 nev", evq.size(), 4);
      chk_leak("t2", 0, k + 3, 0);
      chk("t2 ndone", doneq.size(), 1);
      chk("t2 done", dn(0), k + 13);

      // 3: clear applies to exactly one sweep
      clr_log();
      k = now();
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      run(14);
      chk("t3a nev", evq.size(), 4);
      chk_leak("t3a", 0, k + 4, 1);
      chk("t3a done", dn(0), k + 14);
      clr_log();
      k = now();
      tick = 1'b1;
      step();
      tick = 1'b0;
      run(15);
      chk("t3b nev", evq.size(), 4);
      chk_leak("t3b", 0, k + 3, 0);

      // 4: tick mid-SYN, then second tick -> overrun
      clr_log();
      k = now();
      aer.aer_in_valid = 1'b1;
      aer.aer_in_addr  = 8'd5;
      step();
      aer.aer_in_valid = 1'b0;
      step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
      step();
      chk("t4 ovr0", int'(tick_overrun), 0);
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("t4 ovr1", int'(tick_overrun), 1);
      run(12);
      chk("t4 ready run", rdy_cnt, 0);
      chk("t4 no reads", rd_cnt, 0);
      step();
      chk("t4 done now", int'(sweep_done), 1);
      chk("t4 ready end", int'(aer.aer_in_ready), 1);
      run(2);
      chk("t4 nev", evq.size(), 6);
      chk_ev("t4 e0", 0, k + 3, EXC, 0, 3, 0);
      chk_ev("t4 e1", 1, k + 4, INH, 1, 10, 0);
      chk_leak("t4", 2, k + 9, 0);
      chk("t4 done0", dn(0), k + 7);
      chk("t4 done1", dn(1), k + 19);

      // 5: tick and spike together
      clr_log();
      k = now();
      tick = 1'b1;
      aer.aer_in_valid = 1'b1;
      aer.aer_in_addr  = 8'd5;
      #1 chk("t5 ready0", int'(aer.aer_in_ready), 0);
      step();
      tick = 1'b0;
      chk("t5 no hs", int'(syn_rd_en), 0);
      run(12);
      chk("t5 ready cnt", rdy_cnt, 1);
      chk("t5 done now", int'(sweep_done), 1);
      chk("t5 ready end", int'(aer.aer_in_ready), 1);
      step();
      aer.aer_in_valid = 1'b0;
      chk("t5 rd_en", int'(syn_rd_en), 1);
      chk("t5 rd_addr", int'(syn_rd_addr), 20);
      run(8);
      chk("t5 nev", evq.size(), 6);
      chk_leak("t5", 0, k + 3, 0);
      chk_ev("t5 e4", 4, k + 16, EXC, 0, 3, 0);
      chk_ev("t5 e5", 5, k + 17, INH, 1, 10, 0);
      chk("t5 done0", dn(0), k + 13);
      chk("t5 done1", dn(1), k + 20);

      // 6: reset mid-SYN
      clr_log();
      k = now();
      aer.aer_in_valid = 1'b1;
      aer.aer_in_addr  = 8'd5;
      step();
      aer.aer_in_valid = 1'b0;
      step();
      step();
      chk("t6 ovr pre", int'(tick_overrun), 1);
      rst = 1'b1;
      step();
      chk("t6 outs", outs(), 0);
      chk("t6 naddr", int'(neur_addr), 0);
      chk("t6 wgt", int'(syn_weight), 0);
      rst = 1'b0;
      #1 chk("t6 ready", int'(aer.aer_in_ready), 1);
      run(8);
      chk("t6 no reads", rd_cnt, 0);
      chk("t6 nev", evq.size(), 1);
      chk_ev("t6 e0", 0, k + 3, EXC, 0, 3, 0);
      chk("t6 ndone", doneq.size(), 0);
      chk("t6 outs end", outs(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
